// File: rtl/addsub_pkg.sv
// Shared types for the serial add/subtract unit: FSM states, op encodings
// and a helper for sizing the digit counter.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic OP_SUB = 1'b0;
    localparam logic OP_ADD = 1'b1;

    // Digit counter needs at least one bit even for a single-digit build.
    function automatic int ctr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/addsub_serial_if.sv
// Request/response bundle of the serial add/subtract unit; the requester
// drives start/op/operands, the unit returns busy/done/result/flags.
interface addsub_serial_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             of;
    logic             zero;
    logic             neg;

    modport master (
        output start, op, a, b, b_in,
        input  busy, done, result, c_out, of, zero, neg
    );

    modport slave (
        input  start, op, a, b, b_in,
        output busy, done, result, c_out, of, zero, neg
    );
endinterface

// File: rtl/addsub_serial_sub_digit.sv
// Combinational DIGIT-bit add/subtract slice; subtract uses borrow arithmetic
// (chain = borrow), add uses carry arithmetic (chain = carry).
module sub_digit
    import addsub_pkg::*;
#(
    parameter int DIGIT = 8
) (
    input  logic [DIGIT-1:0] x_i,
    input  logic [DIGIT-1:0] y_i,
    input  logic             op_i,
    input  logic             chain_in_i,
    output logic [DIGIT-1:0] s_o,
    output logic             chain_out_o,
    output logic             chain_msb_o
);

    logic [DIGIT:0] full;

    // One extra bit holds the carry (add) or, via two's-complement wrap, the borrow (sub).
    always_comb begin
        full = '0;
        if (op_i == OP_ADD) begin
            full = {1'b0, x_i} + {1'b0, y_i} + {{DIGIT{1'b0}}, chain_in_i};
        end else begin
            full = {1'b0, x_i} - {1'b0, y_i} - {{DIGIT{1'b0}}, chain_in_i};
        end
    end

    assign s_o         = full[DIGIT-1:0];
    assign chain_out_o = full[DIGIT];

    generate
        if (DIGIT == 1) begin : g_msb_single
            assign chain_msb_o = chain_in_i;
        end else begin : g_msb_multi
            logic [DIGIT-1:0] low;
            always_comb begin
                low = '0;
                if (op_i == OP_ADD) begin
                    low = {1'b0, x_i[DIGIT-2:0]} + {1'b0, y_i[DIGIT-2:0]}
                        + {{(DIGIT-1){1'b0}}, chain_in_i};
                end else begin
                    low = {1'b0, x_i[DIGIT-2:0]} - {1'b0, y_i[DIGIT-2:0]}
                        - {{(DIGIT-1){1'b0}}, chain_in_i};
                end
            end
            assign chain_msb_o = low[DIGIT-1];
        end
    endgenerate

endmodule

// File: rtl/addsub_serial.sv
// Multi-cycle WIDTH-bit add/subtract, DIGIT bits per clock, start/done handshake.
// Build option ADDSUB_SAT_EN clamps the result to signed saturation on overflow.
module addsub_serial
    import addsub_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    addsub_serial_if.slave  bus
);

    localparam int            NDIG = WIDTH / DIGIT;
    localparam int            CW   = ctr_width(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    state_t           state_q;
    logic [CW-1:0]    k_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             op_q;
    logic             chain_q;
    logic [WIDTH-1:0] result_q;
    logic             busy_q;
    logic             done_q;
    logic             c_out_q;
    logic             of_q;
    logic             zero_q;
    logic             neg_q;

    int               base;
    logic [DIGIT-1:0] x_dig;
    logic [DIGIT-1:0] y_dig;
    logic [DIGIT-1:0] s_dig;
    logic             chain_out;
    logic             chain_msb;
    logic             of_fin;
    logic             last_dig;
    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] result_fin;

    always_comb begin
        base  = int'(k_q) * DIGIT;
        x_dig = a_q[base +: DIGIT];
        y_dig = b_q[base +: DIGIT];
    end

    sub_digit #(.DIGIT(DIGIT)) u_slice (
        .x_i         (x_dig),
        .y_i         (y_dig),
        .op_i        (op_q),
        .chain_in_i  (chain_q),
        .s_o         (s_dig),
        .chain_out_o (chain_out),
        .chain_msb_o (chain_msb)
    );

    assign last_dig = (k_q == LAST);
    assign of_fin   = chain_msb ^ chain_out;

    // Merge the new digit into the running result; saturation only matters on the last digit.
    always_comb begin
        result_d              = result_q;
        result_d[base +: DIGIT] = s_dig;
        result_fin            = result_d;
`ifdef ADDSUB_SAT_EN
        if (of_fin) begin
            result_fin = a_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                      : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            k_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_SUB;
            chain_q  <= 1'b0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            c_out_q  <= 1'b0;
            of_q     <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        op_q    <= bus.op;
                        chain_q <= bus.b_in;
                        k_q     <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    chain_q <= chain_out;
                    if (last_dig) begin
                        state_q  <= DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        k_q      <= '0;
                        result_q <= result_fin;
                        c_out_q  <= chain_out;
                        of_q     <= of_fin;
                        zero_q   <= (result_fin == '0);
                        neg_q    <= result_fin[WIDTH-1];
                    end else begin
                        k_q      <= k_q + 1'b1;
                        result_q <= result_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.c_out  = c_out_q;
    assign bus.of     = of_q;
    assign bus.zero   = zero_q;
    assign bus.neg    = neg_q;

endmodule

// File: doc/addsub_serial.md
# addsub_serial

Parametrised multi-cycle add/subtract unit. It processes a WIDTH-bit operation DIGIT bits per clock through a registered carry/borrow chain, and reports result, carry/borrow, signed overflow, zero and negative flags. It uses a start/done handshake and is the area-reduced replacement for the flat 32-bit ripple subtractor in the ALU datapath. The subtract convention (a − b − b_in, borrow out) is unchanged; add mode is new.

## Interface
- WIDTH, 32: operand/result width; must be a multiple of DIGIT.
- DIGIT, 8: bits processed per cycle; NDIG = WIDTH/DIGIT cycles per operation. DIGIT = WIDTH is legal (single RUN cycle).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only when accepted (see Timing).
- op  in  1  0 = subtract (a − b − b_in), 1 = add (a + b + b_in).
- a, b  in  WIDTH  operands; latched at acceptance.
- b_in  in  1  borrow-in (sub) / carry-in (add); latched at acceptance.
- busy  out  1  high while an operation is in RUN.
- done  out  1  one-cycle pulse; result and flags valid.
- result  out  WIDTH  sum/difference.
- c_out  out  1  borrow-out (sub) / carry-out (add).
- of  out  1  signed overflow.
- zero  out  1  result == 0.
- neg  out  1  result[WIDTH-1].

## Operation
- FSM has three states: IDLE, RUN, DONE.
  - IDLE → RUN on start.
  - RUN → DONE after digit NDIG−1 completes.
  - DONE → IDLE, or DONE → RUN if start is asserted in DONE.
- At acceptance the block latches a, b, op and b_in, loads the chain register with b_in, and clears the digit index to 0.
- Each RUN cycle feeds digit k (bits k·DIGIT .. k·DIGIT+DIGIT−1, LSB digit first) and the chain register to the slice:
  - the slice output is written into result digit k;
  - the slice carry/borrow-out updates the chain register;
  - k increments.
- Subtract: c_out = 1 iff unsigned a < b + b_in. Add: c_out = unsigned carry out of bit WIDTH−1.
- of = (chain into bit WIDTH−1) XOR (chain out of bit WIDTH−1), for both modes. It is captured from the final digit.
- zero and neg are evaluated on the final (post-saturation) result.
- result and the flags hold their values from DONE until the next accepted operation completes. The digits of result update progressively during RUN, so result is valid only from done onward.

## Timing
- Reset: state IDLE; busy, done, result, c_out, of, zero and neg all 0.
- Start is accepted in IDLE or DONE. Start during RUN is ignored and does not queue.
- Latency: start accepted at edge 0 → busy high after edge 0 → RUN occupies edges 1..NDIG → done high for the one cycle following edge NDIG. busy is low in the DONE cycle.
- Back-to-back throughput: one operation per NDIG+1 cycles.
- rst_n low during RUN or DONE aborts immediately: no done pulse, all outputs 0, and the partial result is discarded.
- Operand inputs may change freely after acceptance.

## Configuration
- ADDSUB_SAT_EN defined: on of = 1, result clamps to signed saturation. If latched a[WIDTH−1] = 0 the result is 0x7FF…F; otherwise it is 0x800…0.
  - of still reads 1; c_out is unaffected.
  - zero and neg reflect the clamped value.
- ADDSUB_SAT_EN undefined: result wraps modulo 2^WIDTH, and the saturation logic is absent.

## Structure
- Package addsub_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - op encodings OP_SUB = 1'b0 and OP_ADD = 1'b1.
- Sub-module sub_digit: a combinational DIGIT-bit add/subtract slice.
  - Inputs: x, y, op, chain_in.
  - Outputs: s, chain_out, and chain_msb (the chain into the slice MSB, used for of).
  - Subtract is implemented as borrow arithmetic, matching the existing 1-bit subtractor semantics.
- Top level holds the FSM, digit counter ($clog2(NDIG) bits, minimum 1), operand and op registers, chain register, result register, flags and optional saturation.

## Test plan
- WIDTH=32, DIGIT=8: sub a=5, b=3, b_in=0 → result=2, c_out=0, of=0, zero=0; done exactly 5 cycles after the start edge.
- sub a=0, b=1 → result=0xFFFFFFFF, c_out=1, neg=1, of=0; sub a=7, b=7, b_in=0 → result=0, zero=1.
- sub a=0x80000000, b=1 → of=1; result=0x7FFFFFFF without ADDSUB_SAT_EN, and 0x80000000 with it.
- add a=0xFFFFFFFF, b=1 → result=0, c_out=1, zero=1, of=0; add a=0x7FFFFFFF, b=1 → of=1; result=0x80000000 without ADDSUB_SAT_EN, and 0x7FFFFFFF with it.
- Handshake: start held during RUN → ignored; start in the DONE cycle → second operation completes 5 cycles later; DIGIT=32 → done 2 cycles after start.
- Assert rst_n low at the second RUN cycle → no done, all outputs 0; a subsequent sub 9−4 → result=5.
